// File: rtl/alloc_pkg.sv
// Shared definitions for the delay-line SRAM bank allocator.
// Holds the allocator FSM state encodings and the pipeline id width/type.
package alloc_pkg;

   // Allocator FSM states
   localparam logic [1:0] ALLOC_IDLE  = 2'd0;
   localparam logic [1:0] ALLOC_HOLD  = 2'd1;
   localparam logic [1:0] ALLOC_SWEEP = 2'd2;

   // Two DSP pipelines, so a single-bit owner id
   localparam int unsigned PIPE_ID_W = 1;
   typedef logic [PIPE_ID_W-1:0] pipe_id_t;

endpackage

// File: rtl/priority_encoder_lsb.sv
// Lowest-set-bit priority encoder.
//   in_i  : request vector
//   idx_o : index of the lowest set bit (0 when none set)
//   any_o : high when at least one bit of in_i is set
module priority_encoder_lsb #(
   parameter int unsigned Width = 8,
   parameter int unsigned IdxW  = $clog2(Width)
) (
   input  logic [Width-1:0] in_i,
   output logic [IdxW-1:0]  idx_o,
   output logic             any_o
);

   // Scan from the top down so the lowest set bit is written last
   always_comb begin
      idx_o = '0;
      any_o = 1'b0;
      for (int i = int'(Width) - 1; i >= 0; i--) begin
         if (in_i[i]) begin
            idx_o = IdxW'(i);
            any_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sram_bank_allocator.sv
// Delay-line SRAM bank allocator shared by two DSP pipelines.
// Grants the lowest free bank on request (round-robin between pipelines) and
// reclaims all banks of a pipeline with a full-table sweep on release.
//   clk, reset   : clock, asynchronous active-low reset
//   alloc_req    : per-pipeline level-held allocation request
//   release_req  : per-pipeline release-all pulse
//   alloc_ack    : grant pulse, alloc_bank valid alongside
//   alloc_fail   : no-free-bank pulse
//   release_busy : release pending or sweeping, per pipeline
//   release_done : sweep-complete pulse
//   free_count   : number of unowned banks
module sram_bank_allocator
   import alloc_pkg::*;
#(
   parameter int unsigned n_sram_banks = 64,
   parameter int unsigned bank_w       = $clog2(n_sram_banks)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [1:0]        alloc_req,
   input  logic [1:0]        release_req,
   output logic [1:0]        alloc_ack,
   output logic [1:0]        alloc_fail,
   output logic [bank_w-1:0] alloc_bank,
   output logic [1:0]        release_busy,
   output logic [1:0]        release_done,
   output logic [bank_w:0]   free_count
);

   localparam logic [bank_w-1:0] LastIdx = bank_w'(n_sram_banks - 1);

   logic [1:0]                  state_q, state_d;
   logic [n_sram_banks-1:0]     valid_q, valid_d;
   pipe_id_t [n_sram_banks-1:0] owner_q, owner_d;
   logic [1:0]                  rel_pend_q, rel_pend_d;
   pipe_id_t                    rr_q, rr_d;
   logic [bank_w-1:0]           idx_q, idx_d;
   pipe_id_t                    sweep_p_q, sweep_p_d;
   logic [bank_w:0]             free_count_q, free_count_d;
   logic [1:0]                  ack_q, ack_d, fail_q, fail_d, done_q, done_d;
   logic [bank_w-1:0]           bank_q, bank_d;

   logic [1:0]        rel_clr;
   pipe_id_t          sel;
   logic [bank_w-1:0] free_idx;
   logic              free_any;

   priority_encoder_lsb #(
      .Width(n_sram_banks),
      .IdxW (bank_w)
   ) u_free_enc (
      .in_i (~valid_q),
      .idx_o(free_idx),
      .any_o(free_any)
   );

   always_comb begin
      state_d      = state_q;
      valid_d      = valid_q;
      owner_d      = owner_q;
      rr_d         = rr_q;
      idx_d        = idx_q;
      sweep_p_d    = sweep_p_q;
      free_count_d = free_count_q;
      ack_d        = '0;
      fail_d       = '0;
      done_d       = '0;
      bank_d       = '0;
      rel_clr      = '0;
      sel          = '0;

      case (state_q)
         ALLOC_IDLE: begin
            if (rel_pend_q != 2'b00) begin
               sel          = rel_pend_q[0] ? 1'b0 : 1'b1;
               sweep_p_d    = sel;
               rel_clr[sel] = 1'b1;
               idx_d        = '0;
               state_d      = ALLOC_SWEEP;
            end else if (release_req == 2'b00 && alloc_req != 2'b00) begin
               // A release arriving this edge wins; the request is retried later
               sel = (alloc_req == 2'b11) ? rr_q : alloc_req[1];
               if (sel == rr_q) rr_d = ~rr_q;
               if (free_any) begin
                  valid_d[free_idx] = 1'b1;
                  owner_d[free_idx] = sel;
                  bank_d            = free_idx;
                  ack_d[sel]        = 1'b1;
                  free_count_d      = free_count_q - 1'b1;
               end else begin
                  fail_d[sel] = 1'b1;
               end
               state_d = ALLOC_HOLD;
            end
         end
         ALLOC_HOLD: state_d = ALLOC_IDLE;
         ALLOC_SWEEP: begin
            if (valid_q[idx_q] && owner_q[idx_q] == sweep_p_q) begin
               valid_d[idx_q] = 1'b0;
               free_count_d   = free_count_q + 1'b1;
            end
            idx_d = idx_q + 1'b1;
            if (idx_q == LastIdx) begin
               done_d[sweep_p_q] = 1'b1;
               state_d           = ALLOC_IDLE;
            end
         end
         default: state_d = ALLOC_IDLE;
      endcase

      // A new pulse re-pends even if the same pipeline's sweep starts this edge
      rel_pend_d = (rel_pend_q & ~rel_clr) | release_req;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= ALLOC_IDLE;
         valid_q      <= '0;
         owner_q      <= '0;
         rel_pend_q   <= '0;
         rr_q         <= '0;
         idx_q        <= '0;
         sweep_p_q    <= '0;
         free_count_q <= (bank_w+1)'(n_sram_banks);
         ack_q        <= '0;
         fail_q       <= '0;
         done_q       <= '0;
         bank_q       <= '0;
      end else begin
         state_q      <= state_d;
         valid_q      <= valid_d;
         owner_q      <= owner_d;
         rel_pend_q   <= rel_pend_d;
         rr_q         <= rr_d;
         idx_q        <= idx_d;
         sweep_p_q    <= sweep_p_d;
         free_count_q <= free_count_d;
         ack_q        <= ack_d;
         fail_q       <= fail_d;
         done_q       <= done_d;
         bank_q       <= bank_d;
      end
   end

   assign alloc_ack    = ack_q;
   assign alloc_fail   = fail_q;
   assign alloc_bank   = bank_q;
   assign release_done = done_q;
   assign free_count   = free_count_q;
   assign release_busy = rel_pend_q |
                         ((state_q == ALLOC_SWEEP) ? (2'b01 << sweep_p_q) : 2'b00);

endmodule

// File: tb/tb_sram_bank_allocator.sv
// Self-checking bench for sram_bank_allocator: vector table, directed corner
// sequences and randomized traffic against a bank-ownership reference model.
module tb_sram_bank_allocator;

   localparam int NB = 64;
   localparam int BW = 6;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [1:0]    alloc_req = '0;
   logic [1:0]    release_req = '0;
   logic [1:0]    alloc_ack, alloc_fail, release_busy, release_done;
   logic [BW-1:0] alloc_bank;
   logic [BW:0]   free_count;

   sram_bank_allocator #(.n_sram_banks(NB)) dut (
      .clk         (clk),
      .reset       (reset),
      .alloc_req   (alloc_req),
      .release_req (release_req),
      .alloc_ack   (alloc_ack),
      .alloc_fail  (alloc_fail),
      .alloc_bank  (alloc_bank),
      .release_busy(release_busy),
      .release_done(release_done),
      .free_count  (free_count)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: who owns each bank (-1 = free), pending releases,
   // fairness pointer and how many cycles the allocator is still occupied.
   int       m_owner[NB];
   bit [1:0] m_pend;
   bit       m_rr, m_hold, m_sweeping, m_sp;
   int       m_left;
   bit [1:0] e_ack, e_fail, e_done;
   int       e_bank;

   function automatic void model_reset();
      for (int i = 0; i < NB; i++) m_owner[i] = -1;
      m_pend = 0; m_rr = 0; m_hold = 0; m_sweeping = 0; m_sp = 0; m_left = 0;
      e_ack = 0; e_fail = 0; e_done = 0; e_bank = 0;
   endfunction

   function automatic int m_free();
      int n = 0;
      for (int i = 0; i < NB; i++) if (m_owner[i] < 0) n++;
      return n;
   endfunction

   function automatic bit [1:0] m_busy();
      return m_pend | (m_sweeping ? (2'b01 << m_sp) : 2'b00);
   endfunction

   function automatic void model_step(input bit [1:0] areq, input bit [1:0] rreq);
      bit [1:0] clr = 0;
      int p, fb;
      e_ack = 0; e_fail = 0; e_done = 0; e_bank = 0;
      if (m_sweeping) begin
         m_left--;
         if (m_left == 0) begin
            for (int i = 0; i < NB; i++) if (m_owner[i] == int'(m_sp)) m_owner[i] = -1;
            e_done[m_sp] = 1'b1;
            m_sweeping = 0;
         end
      end else if (m_hold) begin
         m_hold = 0;
      end else if (m_pend != 0) begin
         m_sp = m_pend[0] ? 1'b0 : 1'b1;
         clr[m_sp] = 1'b1;
         m_sweeping = 1;
         m_left = NB;
      end else if (rreq == 0 && areq != 0) begin
         p = (areq == 2'b11) ? int'(m_rr) : (areq[1] ? 1 : 0);
         if (p == int'(m_rr)) m_rr = !m_rr;
         fb = -1;
         for (int i = 0; i < NB; i++) if (m_owner[i] < 0) begin fb = i; break; end
         if (fb >= 0) begin m_owner[fb] = p; e_ack[p] = 1'b1; e_bank = fb; end
         else e_fail[p] = 1'b1;
         m_hold = 1;
      end
      m_pend = (m_pend & ~clr) | rreq;
   endfunction

   task automatic check_model();
      chk("ack", int'(alloc_ack), int'(e_ack));
      chk("fail", int'(alloc_fail), int'(e_fail));
      if (e_ack != 0) chk("bank", int'(alloc_bank), e_bank);
      chk("busy", int'(release_busy), int'(m_busy()));
      chk("done", int'(release_done), int'(e_done));
      if (!m_sweeping) chk("free_count", int'(free_count), m_free());
   endtask

   task automatic step();
      @(posedge clk);
      model_step(alloc_req, release_req);
      #1;
      check_model();
   endtask

   // Asynchronous reset applied mid-cycle; outputs must clear immediately
   task automatic do_reset();
      alloc_req = 0; release_req = 0;
      #3 reset = 1'b0;
      #1;
      chk("rst_ack", int'(alloc_ack), 0);
      chk("rst_fail", int'(alloc_fail), 0);
      chk("rst_bank", int'(alloc_bank), 0);
      chk("rst_busy", int'(release_busy), 0);
      chk("rst_done", int'(release_done), 0);
      chk("rst_free", int'(free_count), NB);
      model_reset();
      repeat (2) begin
         @(posedge clk); #1;
         chk("rst_hold_done", int'(release_done), 0);
      end
      #2 reset = 1'b1;
   endtask

   typedef struct {
      logic [1:0] areq;
      logic [1:0] rreq;
      logic [1:0] ack;
      int         bank;
      int         fc;
      logic [1:0] busy;
   } vec_t;

   vec_t tbl[12];

   initial begin
      int cnt, done_at, ack_at, bank_at;
      bit [1:0] prev_ack, prev_fail;

      tbl[0]  = '{2'b01, 2'b00, 2'b01, 0, 63, 2'b00};
      tbl[1]  = '{2'b01, 2'b00, 2'b00, 0, 63, 2'b00};
      tbl[2]  = '{2'b01, 2'b00, 2'b01, 1, 62, 2'b00};
      tbl[3]  = '{2'b00, 2'b00, 2'b00, 0, 62, 2'b00};
      tbl[4]  = '{2'b11, 2'b00, 2'b10, 2, 61, 2'b00};
      tbl[5]  = '{2'b11, 2'b00, 2'b00, 0, 61, 2'b00};
      tbl[6]  = '{2'b11, 2'b00, 2'b01, 3, 60, 2'b00};
      tbl[7]  = '{2'b11, 2'b00, 2'b00, 0, 60, 2'b00};
      tbl[8]  = '{2'b11, 2'b00, 2'b10, 4, 59, 2'b00};
      tbl[9]  = '{2'b00, 2'b00, 2'b00, 0, 59, 2'b00};
      tbl[10] = '{2'b00, 2'b00, 2'b00, 0, 59, 2'b00};
      tbl[11] = '{2'b00, 2'b01, 2'b00, 0, 59, 2'b01};

      model_reset();
      repeat (2) @(posedge clk);
      #1;
      do_reset();

      // Vector table
      for (int i = 0; i < 12; i++) begin
         alloc_req = tbl[i].areq;
         release_req = tbl[i].rreq;
         step();
         chk("tbl_ack", int'(alloc_ack), int'(tbl[i].ack));
         if (tbl[i].ack != 0) chk("tbl_bank", int'(alloc_bank), tbl[i].bank);
         chk("tbl_free", int'(free_count), tbl[i].fc);
         chk("tbl_busy", int'(release_busy), int'(tbl[i].busy));
      end
      release_req = 0;
      repeat (NB + 4) step();

      // Both held from reset: p0 b0, p1 b1, p0 b2, p1 b3, two cycles apart
      do_reset();
      alloc_req = 2'b11;
      for (int i = 0; i < 8; i++) begin
         step();
         if (i % 2 == 0) begin
            chk("rr_ack", int'(alloc_ack), (i % 4 == 0) ? 1 : 2);
            chk("rr_bank", int'(alloc_bank), i / 2);
         end else begin
            chk("rr_gap", int'(alloc_ack), 0);
         end
      end
      alloc_req = 0;
      step();

      // Exhaust every bank, then one more request must fail
      do_reset();
      alloc_req = 2'b01;
      repeat (2 * NB) step();
      step();
      chk("full_fail", int'(alloc_fail), 1);
      chk("full_ack", int'(alloc_ack), 0);
      chk("full_free", int'(free_count), 0);
      alloc_req = 0;
      step(); step();

      // p0 owns 0-3, p1 owns 4-5, then release p0
      do_reset();
      alloc_req = 2'b01; repeat (8) step();
      alloc_req = 2'b10; repeat (4) step();
      alloc_req = 2'b00; step();
      release_req = 2'b01; step();
      release_req = 2'b00;
      cnt = 1;
      done_at = -1;
      for (int i = 0; i < 200; i++) begin
         step();
         if (release_done[0]) begin done_at = i; break; end
         if (release_busy[0]) cnt++;
      end
      chk("rel_done_seen", (done_at >= 0) ? 1 : 0, 1);
      chk("rel_busy_len", cnt, NB + 1);
      chk("rel_busy_fall", int'(release_busy), 0);
      chk("rel_free", int'(free_count), 62);
      alloc_req = 2'b01;
      for (int k = 0; k < 5; k++) begin
         step();
         chk("realloc_bank", int'(alloc_bank), (k < 4) ? k : 6);
         step();
      end
      alloc_req = 0;
      step();

      // release[1] and alloc[1] on the same edge: sweep first, then ack
      do_reset();
      alloc_req = 2'b10; step();
      alloc_req = 2'b00; step();
      alloc_req = 2'b10; release_req = 2'b10; step();
      release_req = 2'b00;
      done_at = -1; ack_at = -1; bank_at = -1;
      for (int i = 0; i < 200; i++) begin
         step();
         if (release_done[1] && done_at < 0) done_at = i;
         if (alloc_ack[1]) begin ack_at = i; bank_at = int'(alloc_bank); break; end
      end
      alloc_req = 0;
      chk("simul_ack_seen", (ack_at >= 0 && done_at >= 0) ? 1 : 0, 1);
      chk("simul_order", (ack_at > done_at) ? 1 : 0, 1);
      chk("simul_bank", bank_at, 0);
      step();

      // Reset during a sweep at index 20
      do_reset();
      alloc_req = 2'b01; step();
      alloc_req = 2'b00; step();
      release_req = 2'b01; step();
      release_req = 2'b00;
      repeat (21) step();
      chk("mid_busy", int'(release_busy), 1);
      do_reset();
      repeat (NB + 4) step();

      // Randomized traffic with level-held request protocol
      do_reset();
      prev_ack = 0; prev_fail = 0;
      for (int c = 0; c < 3000; c++) begin
         for (int p = 0; p < 2; p++) begin
            if (prev_ack[p] || prev_fail[p]) alloc_req[p] = 1'b0;
            else if (!alloc_req[p] && $urandom_range(3) == 0) alloc_req[p] = 1'b1;
            release_req[p] = ($urandom_range(59) == 0);
         end
         step();
         prev_ack = alloc_ack;
         prev_fail = alloc_fail;
      end
      alloc_req = 0; release_req = 0;
      repeat (2 * NB + 8) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
